// File: rtl/set_pattern_driver.sv
// Pattern-ROM driven initiator for the SET candidate-counting interface.
// Optional per-job watchdog is built only when SET_DRV_WATCHDOG_EN is defined.
module set_pattern_driver #(
  parameter int NUM_PAT   = 64,
  parameter int ADDR_W    = 6,
  parameter int ERR_LIMIT = 10,
  parameter int TO_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode_cfg,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_central,
  input  logic [11:0]       rom_radius,
  input  logic [7:0]        rom_expect,
  output logic              en,
  output logic [23:0]       central,
  output logic [11:0]       radius,
  output logic [1:0]        mode,
  input  logic              busy,
  input  logic              valid,
  input  logic [7:0]        candidate,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] first_fail,
  output logic [2:0]        dbg_state
);

  // Handshake: en is a one-cycle request issued only from WAIT_IDLE with busy low;
  // central/radius/mode stay stable until the next LOAD; valid is sampled only in WAIT_VALID.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT_IDLE, S_ISSUE, S_WAIT_VALID, S_CHECK, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PAT - 1);
  localparam logic [7:0]        ERR_LIM  = 8'(ERR_LIMIT);

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q, rom_addr_q, ff_q;
  logic [23:0]         central_q;
  logic [11:0]         radius_q;
  logic [1:0]          mode_q;
  logic [7:0]          exp_q, cand_q, err_q, err_d;
  logic                en_q, running_q, done_q, pass_q;
  logic                mismatch;
  logic                wd_hit;

  assign mismatch = (cand_q != exp_q);
  assign err_d    = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

`ifdef SET_DRV_WATCHDOG_EN
  logic [15:0] wd_q;

  // Both wait states are entered from non-wait states, so the counter is zero on each entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= 16'd0;
    end else if (state_q == S_WAIT_IDLE || state_q == S_WAIT_VALID) begin
      wd_q <= wd_q + 16'd1;
    end else begin
      wd_q <= 16'd0;
    end
  end

  assign wd_hit = (state_q == S_WAIT_IDLE || state_q == S_WAIT_VALID) &&
                  (wd_q == 16'(TO_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      ff_q       <= '0;
      central_q  <= '0;
      radius_q   <= '0;
      mode_q     <= '0;
      exp_q      <= '0;
      cand_q     <= '0;
      err_q      <= '0;
      en_q       <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode_cfg;
            err_q      <= '0;
            pass_q     <= 1'b0;
            ff_q       <= '0;
            idx_q      <= '0;
            rom_addr_q <= '0;
            running_q  <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          central_q <= rom_central;
          radius_q  <= rom_radius;
          exp_q     <= rom_expect;
          state_q   <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (!busy) begin
            en_q    <= 1'b1;
            state_q <= S_ISSUE;
          end else if (wd_hit) begin
            err_q   <= 8'hFF;
            ff_q    <= idx_q;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_ISSUE: state_q <= S_WAIT_VALID;
        S_WAIT_VALID: begin
          if (valid) begin
            cand_q  <= candidate;
            state_q <= S_CHECK;
          end else if (wd_hit) begin
            err_q   <= 8'hFF;
            ff_q    <= idx_q;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch && err_q == 8'd0) ff_q <= idx_q;
          if (err_d >= ERR_LIM || idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
            state_q <= S_DONE;
          end else begin
            idx_q      <= idx_q + ADDR_W'(1);
            rom_addr_q <= idx_q + ADDR_W'(1);
            state_q    <= S_FETCH;
          end
        end
        S_DONE: begin
          running_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign en         = en_q;
  assign central    = central_q;
  assign radius     = radius_q;
  assign mode       = mode_q;
  assign running    = running_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/set_pattern_driver.md
Name: set_pattern_driver

Overview:
- Synthesizable initiator for the SET candidate-counting interface; drives `en`/`central`/`radius`/`mode` and consumes `busy`/`valid`/`candidate`.
- Walks a pattern ROM (central, radius, expected count per entry), issues one job per entry and compares each returned candidate against the expected value.
- Reports pass/fail and an error count. Used for on-chip self-test of SET and as the stimulus source in system-level regressions.

Parameters:
- NUM_PAT, 64, number of patterns per run (1..2^ADDR_W)
- ADDR_W, 6, pattern ROM address width
- ERR_LIMIT, 10, error count at which the run aborts
- TO_CYCLES, 4096, watchdog limit in cycles per job (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run from pattern 0
- mode_cfg  in  2  SET mode for the run; sampled at start
- rom_addr  out  ADDR_W  pattern ROM address
- rom_central  in  24  ROM data, 1-cycle synchronous read latency
- rom_radius  in  12  ROM data, 1-cycle latency
- rom_expect  in  8  ROM data, 1-cycle latency
- en  out  1  SET job request
- central  out  24  SET centre coordinates
- radius  out  12  SET radii
- mode  out  2  SET mode
- busy  in  1  SET busy
- valid  in  1  SET result valid
- candidate  in  8  SET result
- running  out  1  run in progress
- done  out  1  one-cycle pulse at end of run (normal or abort)
- pass  out  1  sticky; 1 if the last run finished with zero errors
- err_cnt  out  8  mismatches in the current or last run, saturating at 255
- first_fail  out  ADDR_W  index of the first mismatching pattern (valid when err_cnt != 0)

Behaviour:
- Reset values: all outputs 0. The FSM is forced to IDLE from any state, including mid-job; `en` drops immediately.
- FSM states and transitions:
  - IDLE: on `start`, latch `mode_cfg` into `mode`, clear `err_cnt`, `pass` and `first_fail`, set `idx`=0, set `running`, go to FETCH.
  - FETCH: drive `rom_addr`=`idx`, go to LOAD.
  - LOAD: register ROM data into `central`/`radius`/`exp_r`, go to WAIT_IDLE.
  - WAIT_IDLE: stay while `busy`=1; when `busy`=0, go to ISSUE.
  - ISSUE: `en`=1 for exactly one cycle, go to WAIT_VALID.
  - WAIT_VALID: stay until `valid`=1; sample `candidate` in that same cycle, go to CHECK.
  - CHECK: compare with `exp_r`. On mismatch, `err_cnt`++ and record `first_fail` if this is the first error. If `err_cnt` reaches ERR_LIMIT, go to DONE. Else if `idx`=NUM_PAT-1, go to DONE. Else `idx`++ and go to FETCH.
  - DONE: pulse `done`, set `pass`=(`err_cnt`==0), clear `running`, go to IDLE.
- Handshake rules:
  - `central`/`radius`/`mode` are registered and held stable from ISSUE until the next LOAD.
  - `en` is never asserted while `busy`=1 or while a job is outstanding.
  - `valid` is ignored outside WAIT_VALID.
- `start` while `running`=1 is ignored. `start` in the same cycle as DONE is ignored.
- Latency per pattern: 5 cycles overhead plus SET processing time.
- Width rules: `idx` wraps never (terminal at NUM_PAT-1); `err_cnt` saturates.
- Simultaneous events:
  - `valid` arriving in the ISSUE cycle is not sampled; SET guarantees `valid` no earlier than 1 cycle after `en`.
  - `busy` and `valid` both high in WAIT_VALID: `valid` takes priority.

Optional Feature:
- Macro SET_DRV_WATCHDOG_EN.
- When defined: a 16-bit counter runs in WAIT_IDLE and WAIT_VALID and resets on each state entry. Reaching TO_CYCLES counts that pattern as an error, sets `err_cnt`=255 and `first_fail`=`idx`, and goes to DONE with `pass`=0.
- When undefined: no counter is built, and the FSM waits indefinitely.

Test Plan:
- Ideal responder (`busy` 2 cycles after `en`, `valid` after 20 cycles, correct candidate), NUM_PAT=64, mode_cfg=2'b01 -> 64 `en` pulses, `done` pulse, `pass`=1, `err_cnt`=0, `mode` held at 2'b01 throughout.
- Responder returns 8'h0D where ROM expects 8'h0C at indices 3 and 7 -> `pass`=0, `err_cnt`=2, `first_fail`=3, all 64 patterns issued.
- Responder always wrong -> abort after index 9, `err_cnt`=10, exactly 10 `en` pulses, then `done`.
- Responder holds `busy`=1 for 50 cycles before each job -> `en` never overlaps `busy`; `central`/`radius` match the ROM entry at each `en`.
- Reset pulled low while in WAIT_VALID at pattern 12 -> `en`=0, `running`=0, `err_cnt`=0 immediately. A later `start` restarts at `rom_addr`=0.
- With SET_DRV_WATCHDOG_EN, responder never raises `valid` -> `done` exactly TO_CYCLES cycles after ISSUE, `err_cnt`=255, `first_fail`=0.
